// File: rtl/decade_counter_pkg.sv
// decade_counter_pkg: shared constants, count type and wrap rule for BCD digit counters.
// Consumers chaining several digits import this to reuse next_count() and count_t.
`timescale 1ns/1ps

package decade_counter_pkg;

  localparam int unsigned MODULUS_DEF = 10;
  localparam int unsigned WIDTH_DEF   = 4;

  typedef logic [WIDTH_DEF-1:0] count_t;

  // Increment-or-wrap; anything at or above the terminal value (including
  // unreachable codes) returns 0 so an illegal state never survives an edge.
  function automatic int unsigned next_count(input int unsigned cur,
                                             input int unsigned modulus);
    int unsigned nxt;
    nxt = 0;
    if (cur < modulus - 1) begin
      nxt = cur + 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/decade_counter.sv
// decade_counter: free-running modulo-MODULUS up-counter (BCD units digit by default).
// Ports:
//   clk   - sole clock, state updates on rising edge
//   rstn  - asynchronous active-low reset, forces count to 0 immediately
//   count - registered count, 0 .. MODULUS-1
`timescale 1ns/1ps

module decade_counter
  import decade_counter_pkg::*;
#(
  parameter int unsigned MODULUS = MODULUS_DEF,
  parameter int unsigned WIDTH   = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  output logic [WIDTH-1:0] count
);

  // Count register; output taken straight from the flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else begin
      count <= WIDTH'(next_count(32'(count), MODULUS));
    end
  end

endmodule

// File: tb/tb_decade_counter.sv
// tb_decade_counter: scoreboard bench for decade_counter (MODULUS=10 and MODULUS=6 instances).
// Stimulus pushes expected values; monitors sample 1 ns after each rising edge and on each
// falling edge, popping one expected value per sample while the queue is non-empty.
`timescale 1ns/1ps

module tb_decade_counter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rstn6;
  logic [3:0] count10;
  logic [2:0] count6;

  int checks = 0;
  int errors = 0;
  int q10[$];
  int q6[$];

  always #5 clk = ~clk;

  decade_counter #(.MODULUS(10), .WIDTH(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .count(count10)
  );

  decade_counter #(.MODULUS(6), .WIDTH(3)) dut6 (
    .clk  (clk),
    .rstn (rstn6),
    .count(count6)
  );

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge; the value expected both just after the edge and at the falling edge.
  task automatic step(input int exp, input bit sel);
    @(posedge clk);
    if (sel) begin
      q6.push_back(exp);
      q6.push_back(exp);
    end else begin
      q10.push_back(exp);
      q10.push_back(exp);
    end
  endtask

  // Monitor for the decade instance.
  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (q10.size() != 0) begin
        e = q10.pop_front();
        chk("count10_post_edge", 32'(count10), e);
      end
      @(negedge clk);
      if (q10.size() != 0) begin
        e = q10.pop_front();
        chk("count10_mid_cycle", 32'(count10), e);
      end
    end
  end

  // Monitor for the modulo-6 instance.
  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (q6.size() != 0) begin
        e = q6.pop_front();
        chk("count6_post_edge", 32'(count6), e);
      end
      @(negedge clk);
      if (q6.size() != 0) begin
        e = q6.pop_front();
        chk("count6_mid_cycle", 32'(count6), e);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rstn  = 1'b0;
    rstn6 = 1'b0;

    // Reset held over two edges: count stays 0.
    step(0, 1'b0);
    step(0, 1'b0);

    // Release between edges, then 1..9, wrap, and two more full sequences.
    #2 rstn = 1'b1;
    for (int i = 1; i <= 30; i++) step(i % 10, 1'b0);

    // Count up to 5, assert reset 3 ns after the edge that produced 5.
    for (int i = 1; i <= 4; i++) step(i, 1'b0);
    @(posedge clk);
    q10.push_back(5);
    #3 rstn = 1'b0;
    q10.push_back(0);
    step(0, 1'b0);
    step(0, 1'b0);
    #2 rstn = 1'b1;
    step(1, 1'b0);
    step(2, 1'b0);
    step(3, 1'b0);

    // Illegal state 12 injected between edges recovers to 0, then counts normally.
    @(posedge clk);
    q10.push_back(4);
    #2 force dut.count = 4'd12;
    #1 release dut.count;
    q10.push_back(12);
    step(0, 1'b0);
    step(1, 1'b0);
    step(2, 1'b0);

    // Modulo-6 instance: reset value, then 1..5, 0, 1..5, 0.
    step(0, 1'b1);
    step(0, 1'b1);
    #2 rstn6 = 1'b1;
    for (int i = 1; i <= 12; i++) step(i % 6, 1'b1);

    @(posedge clk);
    @(posedge clk);
    chk("scoreboard_drained", 32'(q10.size() + q6.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
